// File: rtl/gsu_icache_if.sv
// gsu_icache_if: core fetch port and ROM arbiter port of the GSU instruction cache
interface gsu_icache_if;
  logic        fetch_req;
  logic [23:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  modport slave(
    input  fetch_req, fetch_addr, rom_ack, rom_data,
    output fetch_ack, fetch_data, rom_req, rom_addr
  );
  modport master(
    output fetch_req, fetch_addr, rom_ack, rom_data,
    input  fetch_ack, fetch_data, rom_req, rom_addr
  );
endinterface

// File: rtl/gsu_icache.sv
// gsu_icache: CBR-windowed GSU instruction cache with ROM line fill, bypass and CPU MMIO access
module gsu_icache #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32
) (
  input  logic                 clkin,
  input  logic                 rst_n,
  gsu_icache_if.slave          bus,
  input  logic                 cbr_wr,
  input  logic [15:0]          cbr_in,
  input  logic                 flush,
  input  logic [8:0]           cpu_off,
  input  logic                 cpu_we,
  input  logic [7:0]           cpu_di,
  output logic [7:0]           cpu_do,
  output logic [NUM_LINES-1:0] valid_flags,
  output logic [15:0]          cbr,
  output logic                 busy
);
  localparam int SIZE = LINE_BYTES * NUM_LINES;
  localparam int LB   = $clog2(LINE_BYTES);
  localparam int AW   = $clog2(SIZE);
  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, BYPASS, RESP} state_t;
  state_t state, state_n;
  logic [7:0] ram [SIZE];
  logic [LB-1:0] cnt;
  logic abort_q, rom_req, clr, kill, rom_done, fill_done, in_win;
  logic [15:0] off;
  logic [AW-1:0] idx, fill_idx, cpu_idx;
  logic [7:0] fetch_data;
  logic [23:0] rom_addr;
  logic [NUM_LINES-1:0] set_mask;
  assign clr       = cbr_wr | flush;
  assign kill      = abort_q | clr;
  assign off       = bus.fetch_addr[15:0] - cbr;
  assign in_win    = {1'b0, off} < 17'(SIZE);
  assign idx       = bus.fetch_addr[AW-1:0];
  assign fill_idx  = {idx[AW-1:LB], cnt};
  assign cpu_idx   = AW'(cpu_off) + cbr[AW-1:0];
  assign rom_done  = rom_req & bus.rom_ack;
  assign fill_done = state == FILL & rom_done & (&cnt) & !kill;
  // clear beats any same-cycle set, whether from the fill or from the CPU
  assign set_mask  = (fill_done ? NUM_LINES'(1) << idx[AW-1:LB] : '0)
                   | (cpu_we & (&cpu_idx[LB-1:0]) ? NUM_LINES'(1) << cpu_idx[AW-1:LB] : '0);
  assign bus.fetch_ack  = state == RESP;
  assign bus.fetch_data = fetch_data;
  assign bus.rom_req    = rom_req;
  assign bus.rom_addr   = rom_addr;
  assign busy           = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.fetch_req & !bus.fetch_ack ? LOOKUP : IDLE;
      LOOKUP:  state_n = !in_win ? BYPASS : valid_flags[idx[AW-1:LB]] ? RESP : FILL;
      FILL:    state_n = (rom_done & ((&cnt) | kill)) | (!rom_req & kill) ? LOOKUP : FILL;
      BYPASS:  state_n = rom_done ? RESP : BYPASS;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      abort_q     <= 1'b0;
      rom_req     <= 1'b0;
      rom_addr    <= '0;
      fetch_data  <= '0;
      cpu_do      <= '0;
      valid_flags <= '0;
      cbr         <= '0;
    end else begin
      state       <= state_n;
      cpu_do      <= ram[cpu_idx];
      valid_flags <= clr ? '0 : valid_flags | set_mask;
      if (cbr_wr) cbr <= cbr_in & ~16'(LINE_BYTES - 1);
      // an abort is remembered until the outstanding ROM read has drained
      abort_q <= state == FILL & state_n == FILL & kill;
      if (state == LOOKUP) cnt <= '0;
      else if (state == FILL & rom_done) cnt <= cnt + 1'b1;
      if (rom_done) rom_req <= 1'b0;
      else if (!rom_req & (state == BYPASS | (state == FILL & !kill))) begin
        rom_req  <= 1'b1;
        rom_addr <= state == BYPASS ? bus.fetch_addr : {bus.fetch_addr[23:LB], cnt};
      end
      if (state == LOOKUP & state_n == RESP) fetch_data <= ram[idx];
      else if (state == BYPASS & rom_done) fetch_data <= bus.rom_data;
    end
  always_ff @(posedge clkin) begin
    if (state == FILL & rom_done) ram[fill_idx] <= bus.rom_data;
    if (cpu_we) ram[cpu_idx] <= cpu_di;
  end
endmodule
